// File: rtl/baccarat_fsm_if.sv
// Bundle between the baccarat hand sequencer and the two hand-scoring blocks.
//   pscore, dscore   : hand scores 0-9, combinational from the card registers
//   pcard3           : raw player third card (0 = empty, 1-13 = A..K)
//   load_pcard1..3   : player card register load enables
//   load_dcard1..3   : dealer card register load enables
//   player_win_light : player won or tie
//   dealer_win_light : dealer won or tie
//   hand_done        : hand finished, outcome lights valid
// master = sequencer side, slave = scoring/datapath side.
interface baccarat_fsm_if;
    logic [3:0] pscore;
    logic [3:0] dscore;
    logic [3:0] pcard3;
    logic       load_pcard1;
    logic       load_pcard2;
    logic       load_pcard3;
    logic       load_dcard1;
    logic       load_dcard2;
    logic       load_dcard3;
    logic       player_win_light;
    logic       dealer_win_light;
    logic       hand_done;

    modport master (
        input  pscore, dscore, pcard3,
        output load_pcard1, load_pcard2, load_pcard3,
        output load_dcard1, load_dcard2, load_dcard3,
        output player_win_light, dealer_win_light, hand_done
    );

    modport slave (
        output pscore, dscore, pcard3,
        input  load_pcard1, load_pcard2, load_pcard3,
        input  load_dcard1, load_dcard2, load_dcard3,
        input  player_win_light, dealer_win_light, hand_done
    );
endinterface

// File: rtl/baccarat_fsm.sv
// Sequencer for one baccarat hand: deals four cards, applies the player and
// banker third-card rules, and latches the winner lights.
//   slow_clock : step clock, one state per rising edge
//   resetb     : asynchronous active-low reset
//   bus        : baccarat_fsm_if.master (scores in; load enables, lights,
//                hand_done out)
module baccarat_fsm #(
    parameter logic [3:0] NATURAL_MIN      = 4'd8,
    parameter logic [3:0] PLAYER_STAND_MIN = 4'd6
) (
    input  logic                  slow_clock,
    input  logic                  resetb,
    baccarat_fsm_if.master        bus
);

    typedef enum logic [3:0] {
        S_P1     = 4'd0,
        S_D1     = 4'd1,
        S_P2     = 4'd2,
        S_D2     = 4'd3,
        S_EVAL_P = 4'd4,
        S_P3     = 4'd5,
        S_EVAL_D = 4'd6,
        S_D3     = 4'd7,
        S_RESULT = 4'd8,
        S_DONE   = 4'd9
    } state_t;

    state_t     state;
    state_t     state_next;
    logic       player_drew;
    logic       bank_draw;
    logic [3:0] p3;
    logic [5:0] loads; // {p1, p2, p3, d1, d2, d3}

    always_ff @(posedge slow_clock or negedge resetb) begin
        if (!resetb) begin
            state <= S_P1;
        end else begin
            state <= state_next;
        end
    end

    // Banker third-card decision; p3 is the player's third card value with
    // ten and face cards counting zero.
    always_comb begin
        p3        = (bus.pcard3 >= 4'd10) ? 4'd0 : bus.pcard3;
        bank_draw = 1'b0;
        if (!player_drew) begin
            bank_draw = (bus.dscore <= 4'd5);
        end else begin
            case (bus.dscore)
                4'd0, 4'd1, 4'd2: bank_draw = 1'b1;
                4'd3:             bank_draw = (p3 != 4'd8);
                4'd4:             bank_draw = (p3 >= 4'd2) && (p3 <= 4'd7);
                4'd5:             bank_draw = (p3 >= 4'd4) && (p3 <= 4'd7);
                4'd6:             bank_draw = (p3 >= 4'd6) && (p3 <= 4'd7);
                default:          bank_draw = 1'b0;
            endcase
        end
    end

    always_comb begin
        state_next = state;
        loads      = '0;
        case (state)
            S_P1: begin
                loads      = 6'b100000;
                state_next = S_D1;
            end
            S_D1: begin
                loads      = 6'b000100;
                state_next = S_P2;
            end
            S_P2: begin
                loads      = 6'b010000;
                state_next = S_D2;
            end
            S_D2: begin
                loads      = 6'b000010;
                state_next = S_EVAL_P;
            end
            S_EVAL_P: begin
                if ((bus.pscore >= NATURAL_MIN) || (bus.dscore >= NATURAL_MIN))
                    state_next = S_RESULT;
                else if (bus.pscore < PLAYER_STAND_MIN)
                    state_next = S_P3;
                else
                    state_next = S_EVAL_D;
            end
            S_P3: begin
                loads      = 6'b001000;
                state_next = S_EVAL_D;
            end
            S_EVAL_D: begin
                state_next = bank_draw ? S_D3 : S_RESULT;
            end
            S_D3: begin
                loads      = 6'b000001;
                state_next = S_RESULT;
            end
            S_RESULT: begin
                state_next = S_DONE;
            end
            S_DONE: begin
                state_next = S_DONE;
            end
            default: begin
                state_next = S_P1;
            end
        endcase
    end

    // Loads are gated by resetb so they drop the instant reset asserts,
    // even though the reset state itself (S_P1) would drive load_pcard1.
    always_comb begin
        bus.load_pcard1 = loads[5] & resetb;
        bus.load_pcard2 = loads[4] & resetb;
        bus.load_pcard3 = loads[3] & resetb;
        bus.load_dcard1 = loads[2] & resetb;
        bus.load_dcard2 = loads[1] & resetb;
        bus.load_dcard3 = loads[0] & resetb;
        bus.hand_done   = (state == S_DONE);
    end

    always_ff @(posedge slow_clock or negedge resetb) begin
        if (!resetb) begin
            player_drew          <= 1'b0;
            bus.player_win_light <= 1'b0;
            bus.dealer_win_light <= 1'b0;
        end else begin
            if (state == S_EVAL_P)
                player_drew <= (state_next == S_P3);
            if (state == S_RESULT) begin
                bus.player_win_light <= (bus.pscore >= bus.dscore);
                bus.dealer_win_light <= (bus.dscore >= bus.pscore);
            end
        end
    end

endmodule
